// File: rtl/zcps_pkg.sv
// Shared types and default-width constants for the zero-count packet statistics block.
package zcps_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BYTES = 16;
  localparam int ZC_W          = $clog2(DEF_DATA_W + 1);
  localparam int TOT_W         = $clog2(DEF_DATA_W * DEF_MAX_BYTES + 1);
  localparam int BYTE_W        = $clog2(DEF_MAX_BYTES + 1);

endpackage

// File: rtl/zero_popcount.sv
// Combinational count of zero bits in one data beat (0..DATA_W).
module zero_popcount #(
  parameter int DATA_W = 8,
  localparam int ZC_W = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [ZC_W-1:0]   zero_cnt
);

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      zero_cnt = zero_cnt + ZC_W'(!data[i]);
    end
  end

endmodule

// File: rtl/zero_count_packet_stats.sv
// Per-packet zero-bit statistics over a valid/ready byte stream framed by in_last.
// Optional macro ZCPS_PARITY_EN adds out_parity (XOR of accumulated data bits).
module zero_count_packet_stats #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 16,
  localparam int ZC_W   = $clog2(DATA_W + 1),
  localparam int TOT_W  = $clog2(DATA_W * MAX_BYTES + 1),
  localparam int BYTE_W = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TOT_W-1:0]  out_zeros,
  output logic [BYTE_W-1:0] out_bytes,
  output logic [ZC_W-1:0]   out_max,
  output logic              out_ovf
`ifdef ZCPS_PARITY_EN
  ,
  output logic              out_parity
`endif
);
  import zcps_pkg::*;

  state_t state_q, state_d;

  logic [ZC_W-1:0]   zc;
  logic              accept;
  logic              sat;

  logic [TOT_W-1:0]  acc_zeros_q, acc_zeros_d;
  logic [BYTE_W-1:0] acc_bytes_q, acc_bytes_d;
  logic [ZC_W-1:0]   acc_max_q,   acc_max_d;
  logic              acc_ovf_q,   acc_ovf_d;

  logic [TOT_W-1:0]  res_zeros_q, res_zeros_d;
  logic [BYTE_W-1:0] res_bytes_q, res_bytes_d;
  logic [ZC_W-1:0]   res_max_q,   res_max_d;
  logic              res_ovf_q,   res_ovf_d;

`ifdef ZCPS_PARITY_EN
  logic              acc_par_q, acc_par_d;
  logic              res_par_q, res_par_d;
`endif

  zero_popcount #(.DATA_W(DATA_W)) u_zero_popcount (
    .data     (in_data),
    .zero_cnt (zc)
  );

  assign in_ready = (state_q != OUT);
  assign accept   = in_valid & in_ready;
  assign sat      = (acc_bytes_q == BYTE_W'(MAX_BYTES));

  always_comb begin
    state_d     = state_q;
    acc_zeros_d = acc_zeros_q;
    acc_bytes_d = acc_bytes_q;
    acc_max_d   = acc_max_q;
    acc_ovf_d   = acc_ovf_q;
    res_zeros_d = res_zeros_q;
    res_bytes_d = res_bytes_q;
    res_max_d   = res_max_q;
    res_ovf_d   = res_ovf_q;
`ifdef ZCPS_PARITY_EN
    acc_par_d   = acc_par_q;
    res_par_d   = res_par_q;
`endif

    case (state_q)
      IDLE: begin
        // First beat of a packet loads the accumulators rather than adding.
        if (accept) begin
          acc_zeros_d = TOT_W'(zc);
          acc_bytes_d = BYTE_W'(1);
          acc_max_d   = zc;
          acc_ovf_d   = 1'b0;
`ifdef ZCPS_PARITY_EN
          acc_par_d   = ^in_data;
`endif
          state_d     = in_last ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (sat) begin
            acc_ovf_d = 1'b1;
          end else begin
            acc_zeros_d = acc_zeros_q + TOT_W'(zc);
            acc_bytes_d = acc_bytes_q + BYTE_W'(1);
            acc_max_d   = (zc > acc_max_q) ? zc : acc_max_q;
`ifdef ZCPS_PARITY_EN
            acc_par_d   = acc_par_q ^ (^in_data);
`endif
          end
          if (in_last) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result registers are only touched on the transition into OUT.
    if (accept && in_last) begin
      res_zeros_d = acc_zeros_d;
      res_bytes_d = acc_bytes_d;
      res_max_d   = acc_max_d;
      res_ovf_d   = acc_ovf_d;
`ifdef ZCPS_PARITY_EN
      res_par_d   = acc_par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_zeros_q <= '0;
      acc_bytes_q <= '0;
      acc_max_q   <= '0;
      acc_ovf_q   <= 1'b0;
      res_zeros_q <= '0;
      res_bytes_q <= '0;
      res_max_q   <= '0;
      res_ovf_q   <= 1'b0;
`ifdef ZCPS_PARITY_EN
      acc_par_q   <= 1'b0;
      res_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_zeros_q <= acc_zeros_d;
      acc_bytes_q <= acc_bytes_d;
      acc_max_q   <= acc_max_d;
      acc_ovf_q   <= acc_ovf_d;
      res_zeros_q <= res_zeros_d;
      res_bytes_q <= res_bytes_d;
      res_max_q   <= res_max_d;
      res_ovf_q   <= res_ovf_d;
`ifdef ZCPS_PARITY_EN
      acc_par_q   <= acc_par_d;
      res_par_q   <= res_par_d;
`endif
    end
  end

  assign out_valid  = (state_q == OUT);
  assign out_zeros  = res_zeros_q;
  assign out_bytes  = res_bytes_q;
  assign out_max    = res_max_q;
  assign out_ovf    = res_ovf_q;
`ifdef ZCPS_PARITY_EN
  assign out_parity = res_par_q;
`endif

endmodule

// File: tb/tb_zero_count_packet_stats.sv
// Self-checking bench for zero_count_packet_stats: vector table, hand-written corner sequences,
// and randomized packets compared against a packet-level reference model.
module tb_zero_count_packet_stats;

  localparam int DATA_W    = 8;
  localparam int MAX_BYTES = 16;
  localparam int ZC_W      = $clog2(DATA_W + 1);
  localparam int TOT_W     = $clog2(DATA_W * MAX_BYTES + 1);
  localparam int BYTE_W    = $clog2(MAX_BYTES + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [TOT_W-1:0]  out_zeros;
  logic [BYTE_W-1:0] out_bytes;
  logic [ZC_W-1:0]   out_max;
  logic              out_ovf;
`ifdef ZCPS_PARITY_EN
  logic              out_parity;
`endif

  zero_count_packet_stats #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_zeros (out_zeros),
    .out_bytes (out_bytes),
    .out_max   (out_max),
    .out_ovf   (out_ovf)
`ifdef ZCPS_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] pkt_q[$];
  int m_zeros, m_bytes, m_max, m_ovf;
`ifdef ZCPS_PARITY_EN
  int m_par;
`endif

  typedef struct {
    int               n;
    logic [3:0][7:0]  beats;
    int               zeros;
    int               bytes;
    int               maxz;
    int               ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: packet statistics straight from the beat list.
  task automatic model();
    m_zeros = 0; m_bytes = 0; m_max = 0; m_ovf = 0;
`ifdef ZCPS_PARITY_EN
    m_par = 0;
`endif
    foreach (pkt_q[i]) begin
      if (i < MAX_BYTES) begin
        int z;
        z = DATA_W - $countones(pkt_q[i]);
        m_zeros += z;
        m_bytes += 1;
        if (z > m_max) m_max = z;
`ifdef ZCPS_PARITY_EN
        m_par ^= int'(^pkt_q[i]);
`endif
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int g;
    g = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) chk("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input int max_gap);
    foreach (pkt_q[i]) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
      send_beat(pkt_q[i], (i == pkt_q.size() - 1));
    end
  endtask

  // Called right after the last beat's accepting edge; drains the result.
  task automatic check_result(input string tag, input int z, input int b, input int m, input int o);
    int hold;
    chk({tag, "_valid_latency"}, int'(out_valid), 1);
    chk({tag, "_zeros"}, int'(out_zeros), z);
    chk({tag, "_bytes"}, int'(out_bytes), b);
    chk({tag, "_max"}, int'(out_max), m);
    chk({tag, "_ovf"}, int'(out_ovf), o);
`ifdef ZCPS_PARITY_EN
    chk({tag, "_parity"}, int'(out_parity), m_par);
`endif
    if (out_ready !== 1'b1) begin
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        step();
        chk({tag, "_hold_valid"}, int'(out_valid), 1);
        chk({tag, "_hold_zeros"}, int'(out_zeros), z);
      end
      out_ready = 1'b1;
    end
    step();
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
    chk({tag, "_idle_zeros_held"}, int'(out_zeros), z);
  endtask

  initial begin
    vecs[0] = '{3, {8'h00, 8'h0F, 8'hFF, 8'h00}, 12, 3, 8, 0};
    vecs[1] = '{1, {8'h00, 8'h00, 8'h00, 8'hA5},  4, 1, 4, 0};
    vecs[2] = '{1, {8'h00, 8'h00, 8'h00, 8'hFF},  0, 1, 0, 0};
    vecs[3] = '{1, {8'h00, 8'h00, 8'h00, 8'h00},  8, 1, 8, 0};
    vecs[4] = '{4, {8'h78, 8'h56, 8'h34, 8'h12}, 19, 4, 6, 0};
    vecs[5] = '{2, {8'h00, 8'h00, 8'h7F, 8'hFE},  2, 2, 1, 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_zeros", int'(out_zeros), 0);
    chk("rst_out_bytes", int'(out_bytes), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
`ifdef ZCPS_PARITY_EN
    chk("rst_out_parity", int'(out_parity), 0);
`endif

    // Table-driven packets, beats stored low index first.
    for (int v = 0; v < 6; v++) begin
      pkt_q.delete();
      for (int k = 0; k < vecs[v].n; k++) pkt_q.push_back(vecs[v].beats[k]);
      model();
      send_pkt(0);
      check_result($sformatf("vec%0d", v), vecs[v].zeros, vecs[v].bytes, vecs[v].maxz, vecs[v].ovf);
    end

    // Idle gaps inside a packet.
    pkt_q = '{8'h01, 8'h80};
    model();
    send_beat(8'h01, 1'b0);
    repeat (3) step();
    send_beat(8'h80, 1'b1);
    check_result("gaps", 14, 2, 7, 0);

    // Backpressure: result held, input stalled for five cycles.
    pkt_q = '{8'h00, 8'h0F};
    model();
    out_ready = 1'b0;
    send_pkt(0);
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_zeros", int'(out_zeros), 12);
      chk("bp_bytes", int'(out_bytes), 2);
      chk("bp_max", int'(out_max), 8);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // Overflow: 20 zero beats.
    pkt_q.delete();
    repeat (20) pkt_q.push_back(8'h00);
    model();
    send_pkt(0);
    check_result("ovf20", 128, 16, 8, 1);

    // Exactly MAX_BYTES beats: saturated count but no overflow.
    pkt_q.delete();
    repeat (16) pkt_q.push_back(8'h00);
    model();
    send_pkt(0);
    check_result("full16", 128, 16, 8, 0);

    // Beats past saturation must not feed zeros or max.
    pkt_q.delete();
    repeat (16) pkt_q.push_back(8'hFF);
    pkt_q.push_back(8'h00);
    model();
    send_pkt(0);
    check_result("ovf_ignored", 0, 16, 0, 1);

    // Reset mid-packet discards the partial packet and prior result.
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_valid0", int'(out_valid), 0);
    step();
    rst = 1'b0;
    chk("midrst_valid1", int'(out_valid), 0);
    chk("midrst_zeros", int'(out_zeros), 0);
    chk("midrst_ready", int'(in_ready), 1);
    pkt_q = '{8'hF0};
    model();
    send_pkt(0);
    check_result("post_rst", 4, 1, 4, 0);

    // Randomized packets against the reference model.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 20);
      pkt_q.delete();
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 3))
          0:       pkt_q.push_back(8'h00);
          1:       pkt_q.push_back(8'hFF);
          default: pkt_q.push_back(8'($urandom));
        endcase
      end
      model();
      out_ready = ($urandom_range(0, 1) == 1);
      send_pkt(2);
      check_result($sformatf("rnd%0d", p), m_zeros, m_bytes, m_max, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zero_count_packet_stats.md
Name: zero_count_packet_stats

Overview:
- Sequential stage downstream of the per-byte zero counter.
- Consumes a valid/ready byte stream framed by a last flag and, per packet, accumulates:
  - total zero bits,
  - byte count,
  - largest single-byte zero count.
- Presents the packet result on a valid/ready output port to the stats/reporting logic.

Parameters:
- DATA_W, 8, width of each input beat in bits.
- MAX_BYTES, 16, beats accumulated per packet before saturation/overflow.
- Derived constants (not overridable):
  - ZC_W = clog2(DATA_W+1), 4 at the default.
  - TOT_W = clog2(DATA_W*MAX_BYTES+1), 8 at the default.
  - BYTE_W = clog2(MAX_BYTES+1), 5 at the default.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present.
- in_ready  out  1  block can accept the beat.
- in_data  in  DATA_W  beat payload.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  packet result available.
- out_ready  in  1  consumer takes the result.
- out_zeros  out  TOT_W  total zero bits in the packet.
- out_bytes  out  BYTE_W  beats accumulated (saturating).
- out_max  out  ZC_W  largest per-beat zero count.
- out_ovf  out  1  packet exceeded MAX_BYTES beats.

Behaviour:
- Reset (synchronous, active-high, on clk rising edge):
  - state=IDLE; all accumulators 0.
  - out_valid=0, out_zeros=0, out_bytes=0, out_max=0, out_ovf=0.
  - in_ready=1 in the cycle after reset is released.
  - Reset mid-packet or mid-OUT discards everything; no partial result is emitted.
- Accept condition: a beat is accepted when in_valid & in_ready at a rising edge.
- Per-beat zero count: combinational count of 0 bits in in_data, range 0..DATA_W.
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready=1.
  - Accept with in_last=0 → ACCUM; accumulators are loaded from that beat (not added to).
  - Accept with in_last=1 → OUT; the single-beat result is loaded.
- ACCUM:
  - in_ready=1.
  - Each accepted beat: zeros += zc; bytes += 1; max = max(max, zc).
  - Accept with in_last=1 → OUT.
- OUT:
  - in_ready=0; out_valid=1; outputs held stable.
  - out_ready=1 → IDLE; out_valid drops next cycle.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: one bubble cycle between packets; in_ready=0 during every OUT cycle.
- Overflow:
  - Once bytes==MAX_BYTES, further beats are still accepted (in_ready stays 1) but not accumulated.
  - out_ovf latches 1 for that packet.
  - out_bytes, out_zeros and out_max hold their saturated values.
- Widths: TOT_W holds the maximum sum exactly, so there is no wrap within a packet; accumulators never wrap.
- Result registers change only on entry to OUT; they hold their values in IDLE/ACCUM until the next packet completes.
- in_valid=0 cycles inside a packet: state and accumulators hold.

Optional Feature:
- Macro: ZCPS_PARITY_EN.
- Defined:
  - Adds output port out_parity (out, 1) = XOR of all accepted, non-overflow data bits of the packet.
  - Registered and updated with the other results; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package zcps_pkg:
  - FSM state enum {IDLE, ACCUM, OUT}.
  - clog2-based width localparams ZC_W, TOT_W, BYTE_W.
- Sub-module zero_popcount:
  - Combinational, parameter DATA_W.
  - data in → zero count out (ZC_W).
  - Reusable as the per-byte counter stage.

Test Plan:
- Basic packet: 0x00, 0xFF, 0x0F(last), out_ready=1 → one cycle after last: out_valid=1, zeros=12, bytes=3, max=8, ovf=0; out_valid low the following cycle.
- Single-beat packet: 0xA5 with last in IDLE → next cycle out_valid=1, zeros=4, bytes=1, max=4; with ZCPS_PARITY_EN, out_parity=0.
- Backpressure: hold out_ready=0 for 5 cycles during OUT while in_valid=1 → in_ready=0 and all outputs stable for all 5 cycles; out_ready=1 → IDLE, in_ready=1 next cycle.
- Overflow: MAX_BYTES=16, 20 beats of 0x00, last on beat 20 → bytes=16, zeros=128, max=8, ovf=1.
- Gaps: 0x01, idle 3 cycles, 0x80(last) → zeros=14, bytes=2, max=7.
- Reset mid-packet: assert rst after 2 beats of 0x00, release, then send 0xF0(last) → result zeros=4, bytes=1; no out_valid before that packet.
